// File: rtl/pmips_mem_defs.sv
// Shared definitions for the PMIPS memory arbiter: FSM state codes, owner codes
// and default bus widths.
package pmips_mem_defs;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/pmips_mem_grant_sel.sv
// Grant selector for the PMIPS memory arbiter: picks at most one requester.
// Define PMIPS_ARB_RR_EN for round-robin under contention; otherwise data wins.
module pmips_mem_grant_sel
    import pmips_mem_defs::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic rr_ptr,
    output logic grant_if,
    output logic grant_d
);

`ifdef PMIPS_ARB_RR_EN
    // Under contention rr_ptr names the winner; a lone requester always wins.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (if_req && d_req) begin
            grant_d  = (rr_ptr == OWN_D);
            grant_if = (rr_ptr == OWN_IF);
        end else begin
            grant_d  = d_req;
            grant_if = if_req;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = rr_ptr;

    // The MEM-stage instruction is older, so data always beats fetch.
    assign grant_d  = d_req;
    assign grant_if = if_req & ~d_req;
`endif

endmodule

// File: rtl/pmips_mem_arbiter.sv
// Single-port RAM arbiter sharing one block RAM between IF and MEM stages.
// Define PMIPS_ARB_RR_EN to make contended grants alternate (round-robin).
module pmips_mem_arbiter
    import pmips_mem_defs::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 2
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("pmips_mem_arbiter: RD_LAT must be in 1..3");
    end

    localparam logic [1:0] LAT_INIT = RD_LAT[1:0];

    logic [1:0] state;
    logic [1:0] lat_cnt;
    logic       owner;
    logic       rr_ptr;
    logic       grant_if;
    logic       grant_d;
    logic       idle_issue;

`ifdef PMIPS_ARB_RR_EN
    // Flip after every contended grant so neither side gets two in a row.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= OWN_D;
        end else if (state == ST_IDLE && if_req && d_req) begin
            rr_ptr <= ~rr_ptr;
        end
    end
`else
    assign rr_ptr = OWN_D;
`endif

    pmips_mem_grant_sel u_grant_sel (
        .if_req   (if_req),
        .d_req    (d_req),
        .rr_ptr   (rr_ptr),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    // Grants are only acted on in IDLE, and never while reset is held.
    assign idle_issue = (state == ST_IDLE) && !reset;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (idle_issue) begin
            if (grant_d) begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_we ? d_wdata : '0;
            end else if (grant_if) begin
                mem_en    = 1'b1;
                mem_addr  = if_addr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            owner    <= OWN_D;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        owner <= OWN_D;
                        if (d_we) begin
                            state <= ST_ACK;
                        end else begin
                            lat_cnt <= LAT_INIT;
                            state   <= ST_RD_WAIT;
                        end
                    end else if (grant_if) begin
                        owner   <= OWN_IF;
                        lat_cnt <= LAT_INIT;
                        state   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    lat_cnt <= lat_cnt - 2'd1;
                    // RAM data is valid in the cycle where the count hits 1.
                    if (lat_cnt == 2'd1) begin
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                        end else begin
                            d_rdata <= mem_rdata;
                        end
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack    = (state == ST_ACK) && (owner == OWN_IF);
    assign d_ack     = (state == ST_ACK) && (owner == OWN_D);
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_pmips_mem_arbiter.sv
// Directed self-checking bench for pmips_mem_arbiter with a 2-cycle RAM model.
// Contention expectations follow PMIPS_ARB_RR_EN when it is defined.
module tb_pmips_mem_arbiter;
    import pmips_mem_defs::*;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    logic [15:0] ram [256];
    logic [15:0] rdStage1;
    logic [15:0] rdStage2;

    int checkCount;
    int errorCount;

`ifdef PMIPS_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    pmips_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM: data for the address of cycle N is valid in cycle N+2.
    always @(posedge clock) begin
        if (reset) begin
            ram[8'h10] <= 16'h1234;
            ram[8'h30] <= 16'h00AA;
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        rdStage1 <= ram[mem_addr];
        rdStage2 <= rdStage1;
    end
    assign mem_rdata = rdStage2;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [7:0] ifAddr, input logic dReq,
                                 input logic dWe, input logic [7:0] dAddr, input logic [15:0] dWdata);
        if_req  = ifReq;
        if_addr = ifAddr;
        d_req   = dReq;
        d_we    = dWe;
        d_addr  = dAddr;
        d_wdata = dWdata;
    endtask

    task automatic nextCycle;
        @(posedge clock);
        #1;
    endtask

    task automatic midCycle;
        @(negedge clock);
    endtask

    initial begin
        logic expectD;
        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        nextCycle;
        nextCycle;
        reset = 1'b0;

        // Reset values
        midCycle;
        checkOutput("rst_if_ack", {31'b0, if_ack}, 32'd0);
        checkOutput("rst_d_ack", {31'b0, d_ack}, 32'd0);
        checkOutput("rst_if_rdata", {16'b0, if_rdata}, 32'd0);
        checkOutput("rst_d_rdata", {16'b0, d_rdata}, 32'd0);
        checkOutput("rst_mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
        checkOutput("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);

        $display("[TB] fetch only");
        nextCycle;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000);
        midCycle;
        checkOutput("f_c0_mem_en", {31'b0, mem_en}, 32'd1);
        checkOutput("f_c0_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("f_c0_mem_addr", {24'b0, mem_addr}, 32'h10);
        checkOutput("f_c0_stall_if", {31'b0, stall_if}, 32'd1);
        for (int c = 1; c <= 2; c++) begin
            nextCycle;
            midCycle;
            checkOutput("f_wait_stall_if", {31'b0, stall_if}, 32'd1);
            checkOutput("f_wait_mem_en", {31'b0, mem_en}, 32'd0);
            checkOutput("f_wait_if_ack", {31'b0, if_ack}, 32'd0);
        end
        nextCycle;
        midCycle;
        checkOutput("f_c3_if_ack", {31'b0, if_ack}, 32'd1);
        checkOutput("f_c3_if_rdata", {16'b0, if_rdata}, 32'h1234);
        checkOutput("f_c3_stall_if", {31'b0, stall_if}, 32'd0);
        nextCycle;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        midCycle;
        checkOutput("f_c4_if_ack", {31'b0, if_ack}, 32'd0);

        $display("[TB] store then fetch");
        nextCycle;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 16'hBEEF);
        midCycle;
        checkOutput("s_c0_mem_en", {31'b0, mem_en}, 32'd1);
        checkOutput("s_c0_mem_we", {31'b0, mem_we}, 32'd1);
        checkOutput("s_c0_mem_addr", {24'b0, mem_addr}, 32'h20);
        checkOutput("s_c0_mem_wdata", {16'b0, mem_wdata}, 32'hBEEF);
        checkOutput("s_c0_stall_mem", {31'b0, stall_mem}, 32'd1);
        nextCycle;
        midCycle;
        checkOutput("s_c1_d_ack", {31'b0, d_ack}, 32'd1);
        checkOutput("s_c1_mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("s_c1_stall_mem", {31'b0, stall_mem}, 32'd0);
        nextCycle;
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 16'h0000);
        midCycle;
        checkOutput("s_fetch_issue", {31'b0, mem_en}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            nextCycle;
            midCycle;
        end
        checkOutput("s_fetch_ack", {31'b0, if_ack}, 32'd1);
        checkOutput("s_fetch_rdata", {16'b0, if_rdata}, 32'hBEEF);
        checkOutput("s_d_rdata_hold", {16'b0, d_rdata}, 32'h0000);
        nextCycle;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);

        $display("[TB] contention");
        nextCycle;
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 16'h0000);
        midCycle;
        checkOutput("c_c0_mem_addr", {24'b0, mem_addr}, 32'h30);
        checkOutput("c_c0_stall_if", {31'b0, stall_if}, 32'd1);
        checkOutput("c_c0_stall_mem", {31'b0, stall_mem}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            nextCycle;
            midCycle;
        end
        checkOutput("c_c3_d_ack", {31'b0, d_ack}, 32'd1);
        checkOutput("c_c3_d_rdata", {16'b0, d_rdata}, 32'h00AA);
        checkOutput("c_c3_if_ack", {31'b0, if_ack}, 32'd0);
        checkOutput("c_c3_mem_en", {31'b0, mem_en}, 32'd0);
        nextCycle;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000);
        midCycle;
        checkOutput("c_c4_mem_en", {31'b0, mem_en}, 32'd1);
        checkOutput("c_c4_mem_addr", {24'b0, mem_addr}, 32'h10);
        nextCycle;
        midCycle;
        checkOutput("c_c5_stall_if", {31'b0, stall_if}, 32'd1);
        nextCycle;
        nextCycle;
        midCycle;
        checkOutput("c_c7_if_ack", {31'b0, if_ack}, 32'd1);
        checkOutput("c_c7_if_rdata", {16'b0, if_rdata}, 32'h1234);
        checkOutput("c_c7_d_rdata_hold", {16'b0, d_rdata}, 32'h00AA);
        nextCycle;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);

        $display("[TB] reset mid-read");
        nextCycle;
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 16'h0000);
        midCycle;
        checkOutput("r_c0_mem_en", {31'b0, mem_en}, 32'd1);
        nextCycle;
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        nextCycle;
        reset = 1'b0;
        midCycle;
        checkOutput("r_c2_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
        checkOutput("r_c2_if_rdata", {16'b0, if_rdata}, 32'd0);
        checkOutput("r_c2_d_rdata", {16'b0, d_rdata}, 32'd0);
        checkOutput("r_c2_mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("r_c2_mem_addr", {24'b0, mem_addr}, 32'd0);
        for (int c = 2; c <= 5; c++) begin
            if (c > 2) begin
                nextCycle;
                midCycle;
            end
            checkOutput("r_no_if_ack", {31'b0, if_ack}, 32'd0);
            checkOutput("r_if_rdata_zero", {16'b0, if_rdata}, 32'd0);
        end

        $display("[TB] request held past ack");
        nextCycle;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0000);
        midCycle;
        for (int c = 1; c <= 3; c++) begin
            nextCycle;
            midCycle;
        end
        checkOutput("h_c3_if_ack", {31'b0, if_ack}, 32'd1);
        checkOutput("h_c3_mem_en", {31'b0, mem_en}, 32'd0);
        nextCycle;
        midCycle;
        checkOutput("h_c4_if_ack", {31'b0, if_ack}, 32'd0);
        checkOutput("h_c4_mem_en", {31'b0, mem_en}, 32'd1);
        checkOutput("h_c4_mem_addr", {24'b0, mem_addr}, 32'h10);
        checkOutput("h_c4_stall_if", {31'b0, stall_if}, 32'd1);
        nextCycle;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        nextCycle;
        nextCycle;
        midCycle;
        checkOutput("h_c7_if_ack_dropped", {31'b0, if_ack}, 32'd1);
        checkOutput("h_c7_stall_if", {31'b0, stall_if}, 32'd0);
        nextCycle;

        $display("[TB] continuous contention");
        nextCycle;
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h30, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            expectD = RR_EN ? ((k % 2) == 0) : 1'b1;
            midCycle;
            checkOutput("cc_issue_en", {31'b0, mem_en}, 32'd1);
            checkOutput("cc_issue_addr", {24'b0, mem_addr}, expectD ? 32'h30 : 32'h10);
            for (int c = 1; c <= 3; c++) begin
                nextCycle;
                midCycle;
            end
            checkOutput("cc_d_ack", {31'b0, d_ack}, {31'b0, expectD});
            checkOutput("cc_if_ack", {31'b0, if_ack}, {31'b0, ~expectD});
            nextCycle;
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
        midCycle;
        checkOutput("cc_idle_mem_en", {31'b0, mem_en}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pmips_mem_arbiter.md
# pmips_mem_arbiter

Single-port memory arbiter for the PMIPS pipeline. Shares one synchronous block RAM between the instruction-fetch (IF) stage and the data-access (MEM) stage for lw/sw. Sequences each access through a small FSM that handles a configurable RAM read latency. Drives per-stage stall signals that the hazard/stall controller ORs into its PC-stall and bubble logic.

## Interface
Parameters:
- ADDR_W, 8, word-address width
- DATA_W, 16, word width (16-bit instructions and data)
- RD_LAT, 2, cycles from RAM address to valid mem_rdata; legal range 1..3

Ports:
- clock  in  1  system clock; everything samples on posedge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle
- if_rdata  out  DATA_W  fetched instruction (registered)
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse; completes the data request
- d_rdata  out  DATA_W  load data (registered); valid with d_ack when d_we=0
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- stall_if  out  1  if_req & ~if_ack
- stall_mem  out  1  d_req & ~d_ack

## Operation
- FSM states: IDLE, RD_WAIT, ACK.
- IDLE:
  - The grant selector picks a requester. mem_en, mem_we, mem_addr and mem_wdata are driven combinationally in the same cycle. This is the issue cycle.
  - Granted read: load lat_cnt = RD_LAT, record the owner (IF or D), go to RD_WAIT.
  - Granted write: mem_we=1, go to ACK. Writes are data-only.
  - No request: all mem_* = 0, stay in IDLE.
- RD_WAIT:
  - Decrement lat_cnt each cycle; mem_en=0.
  - When lat_cnt reaches 1, capture mem_rdata into the owner's rdata register and go to ACK.
- ACK:
  - Pulse the owner's ack.
  - No grant is made in ACK, because requests are still high for this cycle.
  - Go to IDLE.
- Grant rule without the macro: fixed priority, data over fetch. The older instruction always wins.
- lat_cnt is 2 bits wide. RD_LAT outside 1..3 is an elaboration error.
- If a request drops mid-transaction, the transaction still completes and the ack still pulses.
- The non-owner's rdata register holds its last value.
- Reset mid-transaction: the transaction is abandoned with no ack, the FSM returns to IDLE, and the late mem_rdata is ignored.

## Timing
- Reset values: state=IDLE, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rr_ptr=data. stall_* follow the requests combinationally.
- Read latency: issue in cycle 0, ack in cycle RD_LAT+1.
- Write latency: issue in cycle 0, ack in cycle 1.
- Back-to-back throughput:
  - Reads: one per RD_LAT+2 cycles.
  - Writes: one per 2 cycles.
- Simultaneous if_req and d_req: exactly one is granted. The loser stays stalled and is granted in the first IDLE cycle after the winner's ACK.
- Requests are sampled only in IDLE. A request arriving while the FSM is busy waits; stall_* is high throughout the wait.

## Configuration
- PMIPS_ARB_RR_EN defined:
  - When both requesters contend, grant goes round-robin.
  - rr_ptr resets to data and flips to the other requester after every grant made under contention.
  - A lone requester is always granted.
- PMIPS_ARB_RR_EN not defined:
  - Fixed data priority; rr_ptr is not implemented.

## Structure
- Shared package/include pmips_mem_defs:
  - FSM state encodings
  - owner encoding: OWN_IF=0, OWN_D=1
  - default ADDR_W and DATA_W
- One sub-module, pmips_mem_grant_sel:
  - Combinational.
  - Inputs: if_req, d_req, rr_ptr.
  - Outputs: grant_if, grant_d (one-hot or none).
  - Contains the PMIPS_ARB_RR_EN ifdef.
- The FSM, lat_cnt, the rdata registers and the mem_* muxing live in the top module.

## Test plan
All scenarios use RD_LAT=2.
1. Fetch only: if_addr=0x10, RAM[0x10]=0x1234 -> mem_en=1 with mem_addr=0x10 in cycle 0; if_ack with if_rdata=0x1234 in cycle 3; stall_if high in cycles 0–2.
2. Store then fetch: d_we=1, d_addr=0x20, d_wdata=0xBEEF -> mem_we=1 in cycle 0, d_ack in cycle 1. A following fetch of 0x20 returns 0xBEEF.
3. Contention, macro off: if_req and d_req (load, 0x30 holding 0x00AA) both raised in cycle 0 -> d_ack with d_rdata=0x00AA in cycle 3; fetch issued in cycle 4, if_ack in cycle 7.
4. Contention, macro on, both requesters re-requesting continuously -> grants alternate D, IF, D, IF; no requester receives two consecutive contended grants.
5. Reset mid-read: reset asserted in cycle 1 of a fetch -> no if_ack at any time; in cycle 2 state=IDLE and all outputs are at reset values.
6. Requester holds req one cycle past its ack -> no mem_en in the ACK cycle; re-issue happens only in the following IDLE cycle.
